// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) answering the bridge's device port.
// Combinational read-back, clocked writes, level IRQ gated by CTRL.IM.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  logic [1:0]  r_state;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_enable;
  logic w_autoreload;
  logic w_unmask;
  logic w_flag_ack;
  logic w_expire;
  logic w_unused_addr;

  assign w_wr_ctrl    = WE && (Addr[3:2] == A_CTRL);
  assign w_wr_preset  = WE && (Addr[3:2] == A_PRESET);
  assign w_enable     = r_ctrl[0];
  assign w_autoreload = (r_ctrl[2:1] == 2'b01);
  // A CTRL write that raises IM is an unmask, not an acknowledge: the pending flag survives it.
  assign w_unmask     = w_wr_ctrl && !r_ctrl[3] && DIn[3];
  assign w_flag_ack   = (w_wr_ctrl && !w_unmask) || w_wr_preset;
  assign w_expire     = (r_state == S_CNT) && w_enable && (r_count <= 32'd1);
  assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      // Software CTRL write outranks the one-shot hardware Enable clear in INT.
      if (w_wr_ctrl) begin
        r_ctrl <= DIn[3:0];
      end else if ((r_state == S_INT) && !w_autoreload) begin
        r_ctrl[0] <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= DIn;
      end

      if (w_expire) begin
        r_irq_flag <= 1'b1;
      end else if ((r_state == S_INT) && w_autoreload) begin
        r_irq_flag <= 1'b0;
      end else if (w_flag_ack) begin
        r_irq_flag <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_enable) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!w_enable) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count <= 32'd0;
            r_state <= S_INT;
          end
        end
        S_INT: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (Addr[3:2])
      A_CTRL:   DOut = {28'd0, r_ctrl};
      A_PRESET: DOut = r_preset;
      A_COUNT:  DOut = r_count;
      default:  DOut = 32'd0;
    endcase
  end

  assign IRQ = r_ctrl[3] && r_irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues hand-computed DOut/IRQ values,
// a negedge monitor pops and compares them against the device outputs.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        i;
  } exp_t;

  exp_t sb_q[$];
  bit   chk_pend = 1'b0;
  int   total = 0;
  int   bad   = 0;

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (chk_pend) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got no expected entry, required one");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        total++;
        if (DOut !== e.d) begin
          bad++;
          $display("FAIL %s DOut: got %h required %h", e.nm, DOut, e.d);
        end
        total++;
        if (IRQ !== e.i) begin
          bad++;
          $display("FAIL %s IRQ: got %b required %b", e.nm, IRQ, e.i);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] din, input bit chk,
                      input logic [31:0] exp_d, input logic exp_i, input string nm);
    exp_t e;
    reset = rst;
    WE    = we;
    Addr  = addr;
    DIn   = din;
    if (chk) begin
      e.nm = nm;
      e.d  = exp_d;
      e.i  = exp_i;
      sb_q.push_back(e);
    end
    chk_pend = chk;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d,
                    input logic exp_i, input string nm);
    step(1'b0, 1'b0, addr, 32'd0, 1'b1, exp_d, exp_i, nm);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] din);
    step(1'b0, 1'b1, addr, din, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic wrc(input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] exp_d, input logic exp_i, input string nm);
    step(1'b0, 1'b1, addr, din, 1'b1, exp_d, exp_i, nm);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = 32'd0; DIn = 32'd0;
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, "");

    // Reset values on every offset
    rd(32'h0, 32'd0, 1'b0, "rst_ctrl");
    rd(32'h4, 32'd0, 1'b0, "rst_preset");
    rd(32'h8, 32'd0, 1'b0, "rst_count");
    rd(32'hC, 32'd0, 1'b0, "rst_unmapped");

    // One-shot, PRESET=3, IM=1
    wr(32'h4, 32'd3);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd0, 1'b0, "os_idle");
    rd(32'h8, 32'd0, 1'b0, "os_load");
    rd(32'h8, 32'd3, 1'b0, "os_cnt3");
    rd(32'h8, 32'd2, 1'b0, "os_cnt2");
    rd(32'h8, 32'd1, 1'b0, "os_cnt1");
    rd(32'h8, 32'd0, 1'b1, "os_int");
    rd(32'h0, 32'h8, 1'b1, "os_ctrl_en_clr");
    rd(32'h8, 32'd0, 1'b1, "os_irq_held");
    wr(32'h0, 32'h8);
    rd(32'h0, 32'h8, 1'b0, "os_ack");

    // Auto-reload, PRESET=2: period 5, one-cycle IRQ
    wr(32'h4, 32'd2);
    wr(32'h0, 32'hB);
    rd(32'h8, 32'd0, 1'b0, "ar_idle");
    rd(32'h8, 32'd0, 1'b0, "ar_load");
    rd(32'h8, 32'd2, 1'b0, "ar_cnt2");
    rd(32'h8, 32'd1, 1'b0, "ar_cnt1");
    rd(32'h8, 32'd0, 1'b1, "ar_int1");
    rd(32'h8, 32'd0, 1'b0, "ar_idle2");
    rd(32'h8, 32'd0, 1'b0, "ar_load2");
    rd(32'h8, 32'd2, 1'b0, "ar_cnt2b");
    rd(32'h8, 32'd1, 1'b0, "ar_cnt1b");
    rd(32'h8, 32'd0, 1'b1, "ar_int2");
    rd(32'h8, 32'd0, 1'b0, "ar_idle3");
    rd(32'h0, 32'hB, 1'b0, "ar_enable_kept");
    wr(32'h0, 32'h0);
    rd(32'h8, 32'd1, 1'b0, "ar_stop_freeze");
    rd(32'h8, 32'd1, 1'b0, "ar_stop_idle");

    // Mid-count disable freezes COUNT, re-enable reloads
    wr(32'h4, 32'd7);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd1, 1'b0, "mc_idle");
    rd(32'h8, 32'd1, 1'b0, "mc_load");
    rd(32'h8, 32'd7, 1'b0, "mc_cnt7");
    rd(32'h8, 32'd6, 1'b0, "mc_cnt6");
    wrc(32'h0, 32'h0, 32'h9, 1'b0, "mc_dis_wr");
    rd(32'h8, 32'd4, 1'b0, "mc_frozen_a");
    rd(32'h8, 32'd4, 1'b0, "mc_frozen_b");
    rd(32'h0, 32'h0, 1'b0, "mc_ctrl");
    wr(32'h0, 32'h1);
    rd(32'h8, 32'd4, 1'b0, "mc_re_idle");
    rd(32'h8, 32'd4, 1'b0, "mc_re_load");
    rd(32'h8, 32'd7, 1'b0, "mc_reload7");
    rd(32'h8, 32'd6, 1'b0, "mc_reload6");
    wr(32'h0, 32'h0);
    idle();
    idle();

    // PRESET=0, IM=0: flag set masked, unmask raises IRQ
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h1);
    rd(32'h8, 32'd4, 1'b0, "p0_idle");
    rd(32'h8, 32'd4, 1'b0, "p0_load");
    rd(32'h8, 32'd0, 1'b0, "p0_cnt");
    rd(32'h8, 32'd0, 1'b0, "p0_int_masked");
    rd(32'h0, 32'h0, 1'b0, "p0_ctrl");
    wrc(32'h0, 32'h8, 32'h0, 1'b0, "p0_unmask_wr");
    rd(32'h0, 32'h8, 1'b1, "p0_unmasked");
    rd(32'h8, 32'd0, 1'b1, "p0_irq_level");

    // Read-only / unmapped writes and address aliasing
    wrc(32'h8, 32'hDEAD, 32'd0, 1'b1, "ro_count_wr");
    wrc(32'hC, 32'hFFFF_FFFF, 32'd0, 1'b1, "ro_unmapped_wr");
    rd(32'h0, 32'h8, 1'b1, "ro_ctrl");
    rd(32'h4, 32'd0, 1'b1, "ro_preset");
    rd(32'h8, 32'd0, 1'b1, "ro_count");
    rd(32'hC, 32'd0, 1'b1, "ro_unmapped");
    wr(32'h25, 32'h1234_5678);
    rd(32'h14, 32'h1234_5678, 1'b0, "alias_preset");
    wr(32'h0, 32'hFFFF_FFF0);
    rd(32'h3, 32'h0, 1'b0, "ctrl_upper_ignored");

    // Set beats clear; INT-cycle CTRL write keeps Enable
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    rd(32'h8, 32'd0, 1'b0, "pr_idle");
    rd(32'h8, 32'd0, 1'b0, "pr_load");
    rd(32'h8, 32'd2, 1'b0, "pr_cnt2");
    wrc(32'h4, 32'd5, 32'd2, 1'b0, "pr_preset_wr");
    wrc(32'h0, 32'h9, 32'h9, 1'b1, "pr_set_wins");
    rd(32'h0, 32'h9, 1'b0, "pr_ctrl_kept");
    rd(32'h4, 32'd5, 1'b0, "pr_new_preset");
    rd(32'h8, 32'd5, 1'b0, "pr_cnt5");
    rd(32'h8, 32'd4, 1'b0, "pr_cnt4");

    // Reset with a simultaneous CTRL write
    step(1'b1, 1'b1, 32'h0, 32'hB, 1'b0, 32'd0, 1'b0, "");
    rd(32'h0, 32'd0, 1'b0, "rw_ctrl");
    rd(32'h4, 32'd0, 1'b0, "rw_preset");
    rd(32'h8, 32'd0, 1'b0, "rw_count");
    rd(32'h8, 32'd0, 1'b0, "rw_count_idle");
    idle();
    idle();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
